// File: rtl/pc_unit_pkg.sv
// Shared definitions for the program-counter unit: op encoding and RAS sizing helper.
package pc_unit_pkg;

   typedef enum logic [2:0] {
      PC_HOLD = 3'd0,
      PC_INC  = 3'd1,
      PC_ADD  = 3'd2,
      PC_SUB  = 3'd3,
      PC_JMP  = 3'd4,
      PC_CALL = 3'd5,
      PC_RET  = 3'd6,
      PC_RSVD = 3'd7
   } pc_op_e;

   // Width of a counter that must hold 0..depth inclusive.
   function automatic int depth_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Decoder-to-PC-unit bundle: command inputs and registered PC/RAS status outputs.
interface pc_unit_if #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
);
   import pc_unit_pkg::*;

   localparam int DW = depth_w(DEPTH);

   // No valid/ready pair: en qualifies op/offset every cycle, and the unit
   // always accepts a qualified op (one per cycle, never back-pressures).
   logic              en;
   pc_op_e            op;
   logic [WIDTH-1:0]  offset;
   logic [WIDTH-1:0]  pc;
   logic [WIDTH-1:0]  top;
   logic [DW-1:0]     depth;
   logic              empty;
   logic              full;
   logic              err;

   modport master (
      output en, op, offset,
      input  pc, top, depth, empty, full, err
   );

   modport slave (
      input  en, op, offset,
      output pc, top, depth, empty, full, err
   );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// pop when empty is ignored; overflow/underflow are reported as strobes.
module pc_ras
   import pc_unit_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           push_data,
   output logic [WIDTH-1:0]           top,
   output logic [depth_w(DEPTH)-1:0]  depth,
   output logic                       empty,
   output logic                       full,
   output logic                       ovf,
   output logic                       udf
);

   localparam int PW = $clog2(DEPTH);
   localparam int DW = depth_w(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [DW-1:0]    cnt;
   logic [PW-1:0]    top_ptr;

   assign full    = (cnt == DW'(DEPTH));
   assign empty   = (cnt == '0);
   assign ovf     = push & full;
   assign udf     = pop & empty;
   assign depth   = cnt;
   assign top_ptr = wr_ptr - PW'(1);
   assign top     = empty ? '0 : mem[top_ptr];

   // When full, wr_ptr already points at the oldest entry, so a push simply
   // overwrites it and the counter saturates.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         cnt    <= '0;
      end else if (push) begin
         mem[wr_ptr] <= push_data;
         wr_ptr      <= wr_ptr + PW'(1);
         if (!full) begin
            cnt <= cnt + DW'(1);
         end
      end else if (pop && !empty) begin
         wr_ptr <= top_ptr;
         cnt    <= cnt - DW'(1);
      end
   end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter with INC/ADD/SUB/JMP/CALL/RET and a return-address stack.
// Optional sticky stack-error flag built when PC_STACK_ERR_EN is defined.
module pc_unit
   import pc_unit_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int STEP      = 1,
   parameter int DEPTH     = 4,
   parameter int RESET_VEC = 0
) (
   input  logic        clk,
   input  logic        reset,
   pc_unit_if.slave    bus
);

   localparam int               DW      = depth_w(DEPTH);
   localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
   localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VEC);

   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] pc_d;
   logic [WIDTH-1:0] ret_addr;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] ras_top;
   logic [DW-1:0]    ras_depth;
   logic             ras_empty;
   logic             ras_full;
   logic             ovf;
   logic             udf;

   assign ret_addr = pc_q + STEP_W;

   // Arithmetic wraps modulo 2^WIDTH; carries and borrows are dropped.
   always_comb begin
      pc_d = pc_q;
      push = 1'b0;
      pop  = 1'b0;
      if (bus.en) begin
         case (bus.op)
            PC_INC:  pc_d = pc_q + STEP_W;
            PC_ADD:  pc_d = pc_q + bus.offset;
            PC_SUB:  pc_d = pc_q - bus.offset;
            PC_JMP:  pc_d = bus.offset;
            PC_CALL: begin
               push = 1'b1;
               pc_d = pc_q + bus.offset;
            end
            PC_RET: begin
               pop = 1'b1;
               if (!ras_empty) begin
                  pc_d = ras_top;
               end
            end
            default: pc_d = pc_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q <= RESET_W;
      end else begin
         pc_q <= pc_d;
      end
   end

   pc_ras #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ras (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .push_data (ret_addr),
      .top       (ras_top),
      .depth     (ras_depth),
      .empty     (ras_empty),
      .full      (ras_full),
      .ovf       (ovf),
      .udf       (udf)
   );

   assign bus.pc    = pc_q;
   assign bus.top   = ras_top;
   assign bus.depth = ras_depth;
   assign bus.empty = ras_empty;
   assign bus.full  = ras_full;

`ifdef PC_STACK_ERR_EN
   logic err_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         err_q <= 1'b0;
      end else if (ovf || udf) begin
         err_q <= 1'b1;
      end
   end

   assign bus.err = err_q;
`else
   logic unused_strobes;
   assign unused_strobes = ovf | udf;
   assign bus.err        = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit (WIDTH=16, STEP=1, DEPTH=4, RESET_VEC=0) with an
// expected-state queue checked by an independent monitor.
module tb_pc_unit;
   import pc_unit_pkg::*;

`ifdef PC_STACK_ERR_EN
   localparam bit ERR_ON = 1'b1;
`else
   localparam bit ERR_ON = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] due;
      logic [15:0] pc;
      logic [15:0] top;
      logic [2:0]  depth;
      logic        empty;
      logic        full;
      logic        err;
   } exp_t;

   logic clk;
   logic reset;
   int   cyc;
   int   total;
   int   bad;
   exp_t exp_q[$];

   pc_unit_if #(.WIDTH(16), .DEPTH(4)) bus ();

   pc_unit #(
      .WIDTH     (16),
      .STEP      (1),
      .DEPTH     (4),
      .RESET_VEC (0)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // clock / cycle counter
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // driver: apply one cycle of inputs and queue the state expected after that edge
   task automatic step(input logic rst, input logic e, input logic [2:0] o,
                       input logic [15:0] off, input logic [15:0] xpc,
                       input logic [15:0] xtop, input logic [2:0] xdep,
                       input logic xerr);
      exp_t x;
      reset      = rst;
      bus.en     = e;
      bus.op     = pc_op_e'(o);
      bus.offset = off;
      x.due   = 32'(cyc + 1);
      x.pc    = xpc;
      x.top   = xtop;
      x.depth = xdep;
      x.empty = (xdep == 3'd0);
      x.full  = (xdep == 3'd4);
      x.err   = ERR_ON & xerr;
      exp_q.push_back(x);
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int at, input logic [31:0] got,
                        input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, at, got, want);
      end
   endtask

   // scoreboard monitor: compare on the falling edge once an entry is due
   always @(negedge clk) begin
      if (exp_q.size() != 0 && exp_q[0].due <= 32'(cyc)) begin
         exp_t x;
         x = exp_q.pop_front();
         check("pc",    cyc, 32'(bus.pc),    32'(x.pc));
         check("top",   cyc, 32'(bus.top),   32'(x.top));
         check("depth", cyc, 32'(bus.depth), 32'(x.depth));
         check("empty", cyc, 32'(bus.empty), 32'(x.empty));
         check("full",  cyc, 32'(bus.full),  32'(x.full));
         check("err",   cyc, 32'(bus.err),   32'(x.err));
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout cyc=%0d got=running want=finished", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      bus.en = 1'b0;
      bus.op = PC_HOLD;
      bus.offset = '0;

      //    rst  en  op       offset    pc        top       dep  err
      step(1'b1, 1'b0, PC_HOLD, 16'h0000, 16'h0000, 16'h0000, 3'd0, 1'b0);
      step(1'b0, 1'b1, PC_INC,  16'h0000, 16'h0001, 16'h0000, 3'd0, 1'b0);
      step(1'b0, 1'b1, PC_INC,  16'h0000, 16'h0002, 16'h0000, 3'd0, 1'b0);
      step(1'b0, 1'b1, PC_INC,  16'h0000, 16'h0003, 16'h0000, 3'd0, 1'b0);
      step(1'b0, 1'b1, PC_ADD,  16'h0010, 16'h0013, 16'h0000, 3'd0, 1'b0);
      step(1'b0, 1'b1, PC_SUB,  16'h0003, 16'h0010, 16'h0000, 3'd0, 1'b0);
      // wrap-around both ways
      step(1'b0, 1'b1, PC_JMP,  16'hFFFF, 16'hFFFF, 16'h0000, 3'd0, 1'b0);
      step(1'b0, 1'b1, PC_INC,  16'h0000, 16'h0000, 16'h0000, 3'd0, 1'b0);
      step(1'b0, 1'b1, PC_SUB,  16'h0001, 16'hFFFF, 16'h0000, 3'd0, 1'b0);
      // single call / return
      step(1'b0, 1'b1, PC_JMP,  16'h0100, 16'h0100, 16'h0000, 3'd0, 1'b0);
      step(1'b0, 1'b1, PC_CALL, 16'h0020, 16'h0120, 16'h0101, 3'd1, 1'b0);
      step(1'b0, 1'b1, PC_RET,  16'h0000, 16'h0101, 16'h0000, 3'd0, 1'b0);
      // five calls: the fifth overwrites the oldest return address 0x0102
      step(1'b0, 1'b1, PC_CALL, 16'h0010, 16'h0111, 16'h0102, 3'd1, 1'b0);
      step(1'b0, 1'b1, PC_CALL, 16'h0010, 16'h0121, 16'h0112, 3'd2, 1'b0);
      step(1'b0, 1'b1, PC_CALL, 16'h0010, 16'h0131, 16'h0122, 3'd3, 1'b0);
      step(1'b0, 1'b1, PC_CALL, 16'h0010, 16'h0141, 16'h0132, 3'd4, 1'b0);
      step(1'b0, 1'b1, PC_CALL, 16'h0010, 16'h0151, 16'h0142, 3'd4, 1'b1);
      step(1'b0, 1'b1, PC_RET,  16'h0000, 16'h0142, 16'h0132, 3'd3, 1'b1);
      step(1'b0, 1'b1, PC_RET,  16'h0000, 16'h0132, 16'h0122, 3'd2, 1'b1);
      step(1'b0, 1'b1, PC_RET,  16'h0000, 16'h0122, 16'h0112, 3'd1, 1'b1);
      step(1'b0, 1'b1, PC_RET,  16'h0000, 16'h0112, 16'h0000, 3'd0, 1'b1);
      step(1'b0, 1'b1, PC_RET,  16'h0000, 16'h0112, 16'h0000, 3'd0, 1'b1);
      // stall with CALL held on op, then reset during the stall
      step(1'b0, 1'b1, PC_CALL, 16'h0100, 16'h0212, 16'h0113, 3'd1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, PC_CALL, 16'h0050, 16'h0212, 16'h0113, 3'd1, 1'b1);
      end
      step(1'b1, 1'b0, PC_CALL, 16'h0050, 16'h0000, 16'h0000, 3'd0, 1'b0);
      // jump, reserved op, hold, back-to-back call/return
      step(1'b0, 1'b1, PC_JMP,  16'h1234, 16'h1234, 16'h0000, 3'd0, 1'b0);
      step(1'b0, 1'b1, PC_RSVD, 16'h5555, 16'h1234, 16'h0000, 3'd0, 1'b0);
      step(1'b0, 1'b1, PC_HOLD, 16'hAAAA, 16'h1234, 16'h0000, 3'd0, 1'b0);
      step(1'b0, 1'b1, PC_CALL, 16'h0010, 16'h1244, 16'h1235, 3'd1, 1'b0);
      step(1'b0, 1'b1, PC_RET,  16'h0000, 16'h1235, 16'h0000, 3'd0, 1'b0);
      // reset with a live entry discards it; a following RET underflows
      step(1'b0, 1'b1, PC_CALL, 16'h0000, 16'h1235, 16'h1236, 3'd1, 1'b0);
      step(1'b1, 1'b1, PC_CALL, 16'h0040, 16'h0000, 16'h0000, 3'd0, 1'b0);
      step(1'b0, 1'b1, PC_RET,  16'h0000, 16'h0000, 16'h0000, 3'd0, 1'b1);

      bus.en = 1'b0;
      bus.op = PC_HOLD;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain got=%0d want=0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit: the next generation of the 16-bit inc/add/sub PC, generalised in width and step, with absolute jump and a hardware return-address stack (RAS) for call/return. It sits at the fetch stage of the core, with the decoder driving `op`/`offset` and the instruction-memory address taken from `pc`. All state updates happen on the rising clock edge, gated by a stall enable.

## Interface
Parameters:
- WIDTH, 16, PC and offset width in bits (≥ 4)
- STEP, 1, increment applied by INC and used as the CALL return offset (< 2^WIDTH)
- DEPTH, 4, RAS entries (power of two, ≥ 2)
- RESET_VEC, 0, PC value after reset

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high; the only reset
- en  in  1  advance enable; 0 = stall, all state held
- op  in  3  command: 0 HOLD, 1 INC, 2 ADD, 3 SUB, 4 JMP, 5 CALL, 6 RET, 7 reserved (= HOLD)
- offset  in  WIDTH  relative offset (ADD/SUB/CALL) or absolute target (JMP)
- pc  out  WIDTH  current program counter
- top  out  WIDTH  current RAS top entry (0 when empty)
- depth  out  clog2(DEPTH)+1  number of valid RAS entries
- empty  out  1  depth == 0
- full  out  1  depth == DEPTH
- err  out  1  sticky stack error (present only with PC_STACK_ERR_EN; otherwise tied 0)

## Operation
- Reset: pc=RESET_VEC, depth=0, RAS contents=0, top=0, empty=1, full=0, err=0.
- en=0: no state change, regardless of op.
- en=1 updates:
  - HOLD/reserved: no change.
  - INC: pc ← pc+STEP.
  - ADD: pc ← pc+offset.
  - SUB: pc ← pc−offset.
  - JMP: pc ← offset.
  - CALL: push pc+STEP, then pc ← pc+offset.
  - RET: pc ← top, then pop.
- Arithmetic is modulo 2^WIDTH; carry and borrow are discarded, so wrap-around is silent (pc=all-ones, INC with STEP=1 → 0).
- RAS is circular. CALL when full overwrites the oldest entry and depth stays at DEPTH (overflow).
- RET when empty: pc unchanged, depth stays 0 (underflow).
- Outputs `top`, `empty`, `full` and `depth` are derived from registered state only. No combinational path from op/offset to any output.

## Timing
- Latency 1: an op sampled at edge N is reflected on `pc`, `top` and `depth` after edge N.
- Back-to-back CALL/RET are allowed every cycle. CALL then RET on consecutive cycles returns to the original pc+STEP.
- Reset has priority over `en` and `op`. Reset asserted mid-sequence discards all stack contents in the same edge.
- Throughput: one op per cycle while en=1.

## Configuration
- Macro: PC_STACK_ERR_EN.
- Defined: `err` sets on the edge of any RAS overflow (CALL when full) or underflow (RET when empty). It stays set until reset. Stack behaviour itself is unchanged.
- Undefined: no error logic is built and `err` is constant 0.

## Structure
- Package `pc_unit_pkg`:
  - op encoding constants/enum (PC_HOLD … PC_RET)
  - depth-width helper function
- Sub-module `pc_ras`:
  - DEPTH×WIDTH register file, write pointer, depth counter
  - push/pop/full/empty logic and overflow/underflow strobes
- `pc_unit` contains the PC register, the adder/subtractor next-pc mux, and the `err` flag.

## Test plan
- Reset, then 3× INC with WIDTH=16, STEP=1 → pc=0,1,2,3. Then ADD 0x0010 → 0x0013. Then SUB 0x0003 → 0x0010.
- pc=0xFFFF, INC → 0x0000. SUB 0x0001 from 0x0000 → 0xFFFF. No error flag.
- At pc=0x0100: CALL 0x0020 → pc=0x0120, top=0x0101, depth=1. Then RET → pc=0x0101, depth=0, empty=1.
- DEPTH=4: 5 CALLs → full=1, depth=4, err=1 (macro on). 4 RETs return the newest four addresses in LIFO order. A 5th RET leaves pc unchanged.
- en=0 with op=CALL for 3 cycles → pc, depth and top unchanged. Reset asserted during the stall → pc=RESET_VEC, depth=0, err=0 after that edge.
- JMP 0x1234 → pc=0x1234. Op 7 → no change.
